// File: rtl/spi_slave_rx_pkg.sv
// Shared types and constants for the SPI slave receive path.
package spi_slave_rx_pkg;

   localparam int unsigned DEF_TIMEOUT_CYC = 65000;
   localparam int unsigned TMO_W           = 16;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } rx_state_e;

   // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
   function automatic bit sample_on_rise(input bit cpol, input bit cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/spi_slave_rx_edge_sync.sv
// Two-flop synchroniser for one asynchronous line plus a third stage for edge detection.
module spi_slave_rx_edge_sync #(
   parameter bit IDLE_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_c,
   output logic fall_c
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= IDLE_VAL;
         s2_q <= IDLE_VAL;
         s3_q <= IDLE_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_c  = s2_q & ~s3_q;
   assign fall_c  = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversampled SCLK/CS_N/MOSI, MSB-first deserialiser, valid/ready output
// buffer with overrun, framing-error and inter-bit timeout reporting.
module spi_slave_rx
   import spi_slave_rx_pkg::*;
#(
   parameter int unsigned DW          = 8,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          spi_sclk,
   input  logic          spi_cs_n,
   input  logic          spi_mosi,
   output logic [DW-1:0] rx_data,
   output logic          rx_valid,
   input  logic          rx_ready,
   output logic          rx_overrun,
   output logic          rx_frame_err,
   output logic          rx_timeout,
   output logic          busy
);

   localparam int unsigned BCW         = $clog2(DW);
   localparam bit          SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic sclk_rise, sclk_fall, sclk_unused_level;
   logic cs_rise, cs_fall, cs_unused_level;
   logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;
   logic sample_c;

   rx_state_e        state_q, state_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [DW-1:0]    shreg_q, shreg_d;
   logic [DW-1:0]    data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;
   logic             tmo_pulse_q, tmo_pulse_d;
   logic             complete;

   spi_slave_rx_edge_sync #(.IDLE_VAL(CPOL)) u_sync_sclk (
      .clk(clk), .rst(rst), .d_i(spi_sclk),
      .level_o(sclk_unused_level), .rise_c(sclk_rise), .fall_c(sclk_fall)
   );

   spi_slave_rx_edge_sync #(.IDLE_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d_i(spi_cs_n),
      .level_o(cs_unused_level), .rise_c(cs_rise), .fall_c(cs_fall)
   );

   spi_slave_rx_edge_sync #(.IDLE_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d_i(spi_mosi),
      .level_o(mosi_lvl), .rise_c(mosi_unused_rise), .fall_c(mosi_unused_fall)
   );

   assign sample_c = SAMPLE_RISE ? sclk_rise : sclk_fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         tmo_q       <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         ovr_q       <= 1'b0;
         ferr_q      <= 1'b0;
         tmo_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tmo_q       <= tmo_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ovr_q       <= ovr_d;
         ferr_q      <= ferr_d;
         tmo_pulse_q <= tmo_pulse_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tmo_d       = tmo_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = valid_q;
      ovr_d       = 1'b0;
      ferr_d      = 1'b0;
      tmo_pulse_d = 1'b0;
      complete    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d = '0;
            tmo_d     = '0;
            if (enable && cs_fall) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!enable) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
               tmo_d     = '0;
            end else begin
               if (sample_c) begin
                  shreg_d = {shreg_q[DW-2:0], mosi_lvl};
                  tmo_d   = '0;
                  if (bit_cnt_q == BCW'(DW - 1)) begin
                     bit_cnt_d = '0;
                     complete  = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BCW'(1);
                  end
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
               // Deselect is judged after this clock's shift, so a final completing bit is clean.
               if (cs_rise) begin
                  ferr_d    = (bit_cnt_d != '0);
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
                  tmo_d     = '0;
               end else if (!sample_c && tmo_q == TMO_LAST) begin
                  tmo_pulse_d = 1'b1;
                  state_d     = ST_IDLE;
                  bit_cnt_d   = '0;
                  tmo_d       = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Output buffer: a same-clock accept frees the slot for the completing word.
      if (complete) begin
         if (!valid_q || rx_ready) begin
            data_d  = shreg_d;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_overrun   = ovr_q;
   assign rx_frame_err = ferr_q;
   assign rx_timeout   = tmo_pulse_q;
   assign busy         = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: one instance per SPI mode; mode 0 uses a short timeout.
module tb_spi_slave_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       mosi = 1'b0;
   logic       rx_ready = 1'b0;
   logic       sclk [4];
   logic       cs_n [4];
   logic [7:0] rx_data [4];
   logic       rx_valid [4];
   logic       rx_overrun [4];
   logic       rx_frame_err [4];
   logic       rx_timeout [4];
   logic       busy [4];

   int n_checks = 0;
   int n_fail   = 0;
   int n_valid [4];
   int n_ovr   [4];
   int n_ferr  [4];
   int n_tmo   [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_rx #(
         .DW(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .TIMEOUT_CYC(g == 0 ? 100 : 65000)
      ) u_dut (
         .clk(clk), .rst(rst), .enable(enable),
         .spi_sclk(sclk[g]), .spi_cs_n(cs_n[g]), .spi_mosi(mosi),
         .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready),
         .rx_overrun(rx_overrun[g]), .rx_frame_err(rx_frame_err[g]),
         .rx_timeout(rx_timeout[g]), .busy(busy[g])
      );
   end

   // Pulse/valid cycle counters, sampled mid-cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         n_valid[i] <= n_valid[i] + int'(rx_valid[i]);
         n_ovr[i]   <= n_ovr[i]   + int'(rx_overrun[i]);
         n_ferr[i]  <= n_ferr[i]  + int'(rx_frame_err[i]);
         n_tmo[i]   <= n_tmo[i]   + int'(rx_timeout[i]);
      end
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input int m, input logic b);
      logic cpol, cpha;
      cpol = ((m / 2) == 1);
      cpha = ((m % 2) == 1);
      if (!cpha) begin
         mosi = b;
         wclk(4);
         sclk[m] = ~cpol;
         wclk(4);
         sclk[m] = cpol;
      end else begin
         sclk[m] = ~cpol;
         mosi = b;
         wclk(4);
         sclk[m] = cpol;
         wclk(4);
      end
   endtask

   task automatic send_bits(input int m, input logic [7:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(m, w[7-i]);
   endtask

   task automatic start_frame(input int m);
      cs_n[m] = 1'b0;
      wclk(4);
   endtask

   task automatic end_frame(input int m);
      wclk(4);
      cs_n[m] = 1'b1;
      wclk(6);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, o0, f0, t0, k;
      for (int i = 0; i < 4; i++) begin
         sclk[i] = ((i / 2) == 1);
         cs_n[i] = 1'b1;
      end
      #2 rst = 1'b0;
      wclk(3);
      check("rst_data",  16'(rx_data[0]),      16'h0000);
      check("rst_valid", 16'(rx_valid[0]),     16'h0000);
      check("rst_ovr",   16'(rx_overrun[0]),   16'h0000);
      check("rst_ferr",  16'(rx_frame_err[0]), 16'h0000);
      check("rst_tmo",   16'(rx_timeout[0]),   16'h0000);
      check("rst_busy",  16'(busy[0]),         16'h0000);
      rst = 1'b1;
      enable = 1'b1;
      wclk(3);

      // 1: single word 0xA5, consumer always ready
      v0 = n_valid[0]; o0 = n_ovr[0]; f0 = n_ferr[0]; t0 = n_tmo[0];
      rx_ready = 1'b1;
      start_frame(0);
      send_bits(0, 8'hA5, 8);
      wclk(4);
      check("t1_busy_on", 16'(busy[0]), 16'h0001);
      cs_n[0] = 1'b1;
      wclk(2);
      check("t1_busy_2clk", 16'(busy[0]), 16'h0001);
      wclk(1);
      check("t1_busy_3clk", 16'(busy[0]), 16'h0000);
      wclk(4);
      check("t1_data",   16'(rx_data[0]), 16'h00A5);
      check("t1_vcyc",   16'(n_valid[0] - v0), 16'd1);
      check("t1_errs",   16'((n_ovr[0] - o0) + (n_ferr[0] - f0) + (n_tmo[0] - t0)), 16'd0);

      // 2: two words, consumer stalled -> overrun on the second
      rx_ready = 1'b0;
      o0 = n_ovr[0];
      start_frame(0);
      send_bits(0, 8'h3C, 8);
      send_bits(0, 8'hC3, 8);
      end_frame(0);
      check("t2_data",  16'(rx_data[0]),  16'h003C);
      check("t2_valid", 16'(rx_valid[0]), 16'h0001);
      check("t2_ovr",   16'(n_ovr[0] - o0), 16'd1);
      rx_ready = 1'b1;
      wclk(1);
      rx_ready = 1'b0;
      check("t2_vclr",  16'(rx_valid[0]), 16'h0000);
      check("t2_hold",  16'(rx_data[0]),  16'h003C);

      // 3: accept on the exact completion clock of the second word
      o0 = n_ovr[0];
      start_frame(0);
      send_bits(0, 8'h3C, 8);
      send_bits(0, 8'hC3, 7);
      mosi = 1'b1;
      wclk(4);
      sclk[0] = 1'b1;
      wclk(2);
      rx_ready = 1'b1;
      wclk(1);
      rx_ready = 1'b0;
      check("t3_data",  16'(rx_data[0]),  16'h00C3);
      check("t3_valid", 16'(rx_valid[0]), 16'h0001);
      wclk(3);
      sclk[0] = 1'b0;
      end_frame(0);
      check("t3_ovr",   16'(n_ovr[0] - o0), 16'd0);
      rx_ready = 1'b1;
      wclk(1);

      // 4: deselect after 5 bits, then a clean 0x81
      v0 = n_valid[0]; f0 = n_ferr[0];
      start_frame(0);
      send_bits(0, 8'hFF, 5);
      end_frame(0);
      check("t4_ferr",  16'(n_ferr[0] - f0),  16'd1);
      check("t4_novld", 16'(n_valid[0] - v0), 16'd0);
      f0 = n_ferr[0];
      start_frame(0);
      send_bits(0, 8'h81, 8);
      end_frame(0);
      check("t4_data",  16'(rx_data[0]),      16'h0081);
      check("t4_vcyc",  16'(n_valid[0] - v0), 16'd1);
      check("t4_clean", 16'(n_ferr[0] - f0),  16'd0);

      // 5: SCLK stalls after 3 bits; timeout 100 idle clocks after the third sample
      v0 = n_valid[0]; f0 = n_ferr[0];
      start_frame(0);
      send_bits(0, 8'hE0, 2);
      mosi = 1'b1;
      wclk(4);
      sclk[0] = 1'b1;
      k = 0;
      while (k < 200) begin
         wclk(1);
         k++;
         if (k == 4) sclk[0] = 1'b0;
         if (rx_timeout[0]) break;
      end
      check("t5_tmo_at", 16'(k), 16'd103);
      check("t5_busy",   16'(busy[0]), 16'h0000);
      send_bits(0, 8'hFF, 8);
      check("t5_stay",   16'(busy[0]), 16'h0000);
      end_frame(0);
      check("t5_novld",  16'(n_valid[0] - v0), 16'd0);
      check("t5_noferr", 16'(n_ferr[0] - f0),  16'd0);

      // 6: modes 1..3 receive 0x5A
      for (int m = 1; m < 4; m++) begin
         v0 = n_valid[m];
         start_frame(m);
         send_bits(m, 8'h5A, 8);
         end_frame(m);
         check($sformatf("t6_m%0d_data", m), 16'(rx_data[m]),      16'h005A);
         check($sformatf("t6_m%0d_vcyc", m), 16'(n_valid[m] - v0), 16'd1);
      end

      // async reset mid-word with a pending word
      rx_ready = 1'b0;
      start_frame(3);
      send_bits(3, 8'h5A, 8);
      end_frame(3);
      check("t6_pend", 16'(rx_valid[3]), 16'h0001);
      start_frame(3);
      send_bits(3, 8'hF0, 4);
      check("t6_busy_mid", 16'(busy[3]), 16'h0001);
      rst = 1'b0;
      #1;
      check("t6_rst_data",  16'(rx_data[3]),  16'h0000);
      check("t6_rst_valid", 16'(rx_valid[3]), 16'h0000);
      check("t6_rst_busy",  16'(busy[3]),     16'h0000);
      check("t6_rst_pulse", 16'({rx_overrun[3], rx_frame_err[3], rx_timeout[3]}), 16'h0000);
      cs_n[3] = 1'b1;
      wclk(2);
      rst = 1'b1;
      wclk(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
